// File: rtl/dpi_stream_sequencer_if.sv
// rtl/dpi_stream_sequencer_if.sv - packet, config and matcher-control bundle for dpi_stream_sequencer
interface dpi_stream_sequencer_if #(
  parameter int SID_W   = 6,
  parameter int KEY_W   = 32,
  parameter int NUM_CAT = 16
);
  logic               pkt_valid;
  logic               pkt_ready;
  logic [7:0]         pkt_data;
  logic               pkt_sop;
  logic               pkt_eop;
  logic [KEY_W-1:0]   pkt_key;
  logic               cfg_we;
  logic [SID_W-1:0]   cfg_addr;
  logic [NUM_CAT-1:0] cfg_mask;
  logic [SID_W-1:0]   stream_id;
  logic               new_stream_id;
  logic               load_state;
  logic [7:0]         char_in;
  logic               char_in_vld;
  logic               eop;
  logic [NUM_CAT-1:0] enable;
  logic               busy;
  logic [31:0]        pkt_count;
  logic [15:0]        evict_count;
  logic               err_sop;

  modport master (
    output pkt_valid, pkt_data, pkt_sop, pkt_eop, pkt_key, cfg_we, cfg_addr, cfg_mask,
    input  pkt_ready, stream_id, new_stream_id, load_state, char_in, char_in_vld, eop,
           enable, busy, pkt_count, evict_count, err_sop
  );

  modport slave (
    input  pkt_valid, pkt_data, pkt_sop, pkt_eop, pkt_key, cfg_we, cfg_addr, cfg_mask,
    output pkt_ready, stream_id, new_stream_id, load_state, char_in, char_in_vld, eop,
           enable, busy, pkt_count, evict_count, err_sop
  );
endinterface

// File: rtl/dpi_stream_sequencer.sv
// rtl/dpi_stream_sequencer.sv - flow-key to stream-slot mapper and matcher-bank control sequencer
module dpi_stream_sequencer #(
  parameter int NUM_STREAMS = 64,
  parameter int SID_W       = 6,
  parameter int KEY_W       = 32,
  parameter int NUM_CAT     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dpi_stream_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOOKUP, LOAD, WAIT, STREAM, DRAIN, EOP} state_t;

  state_t state, state_next;

  logic [KEY_W-1:0]   key_tbl  [NUM_STREAMS];
  logic [NUM_CAT-1:0] mask_tbl [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] valid;
  logic [SID_W-1:0]   rr_ptr;
  logic [KEY_W-1:0]   key_lat;
  logic               first_beat;

  logic [SID_W-1:0]   sid_r;
  logic               new_r;
  logic [NUM_CAT-1:0] enable_r;
  logic [7:0]         char_r;
  logic               char_vld_r;
  logic               eop_r;
  logic [31:0]        pkt_count_r;
  logic [15:0]        evict_count_r;
  logic               err_sop_r;

  logic               ready;
  logic               hs;
  logic               hit, has_free, evict;
  logic [SID_W-1:0]   hit_idx, free_idx, alloc_sid;

  // Descending scan so the last assignment wins: lowest free slot.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
      if (valid[i] && key_tbl[i] == key_lat) begin
        hit     = 1'b1;
        hit_idx = SID_W'(i);
      end
      if (!valid[i]) begin
        has_free = 1'b1;
        free_idx = SID_W'(i);
      end
    end
    alloc_sid = hit ? hit_idx : (has_free ? free_idx : rr_ptr);
    evict     = !hit && !has_free;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.pkt_valid) begin
          if (bus.pkt_sop) state_next = LOOKUP;
          else             ready      = 1'b1;
        end
      end
      LOOKUP: state_next = LOAD;
      LOAD:   state_next = WAIT;
      WAIT:   state_next = STREAM;
      STREAM: begin
        ready = 1'b1;
        if (bus.pkt_valid && bus.pkt_eop) state_next = DRAIN;
      end
      DRAIN:   state_next = EOP;
      EOP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign hs = (state == STREAM) && bus.pkt_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid         <= '0;
      rr_ptr        <= '0;
      key_lat       <= '0;
      first_beat    <= 1'b0;
      sid_r         <= '0;
      new_r         <= 1'b0;
      enable_r      <= '0;
      char_r        <= '0;
      char_vld_r    <= 1'b0;
      eop_r         <= 1'b0;
      pkt_count_r   <= '0;
      evict_count_r <= '0;
      err_sop_r     <= 1'b0;
      for (int i = 0; i < NUM_STREAMS; i++) mask_tbl[i] <= '1;
    end else begin
      char_vld_r <= 1'b0;
      // Registered so eop trails the last character by two cycles.
      eop_r      <= (state == EOP);
      if (bus.cfg_we) mask_tbl[bus.cfg_addr] <= bus.cfg_mask;
      if (state == IDLE && bus.pkt_valid && bus.pkt_sop) key_lat <= bus.pkt_key;
      if (state == LOOKUP) begin
        sid_r    <= alloc_sid;
        new_r    <= !hit;
        enable_r <= mask_tbl[alloc_sid];
        if (!hit) begin
          key_tbl[alloc_sid] <= key_lat;
          valid[alloc_sid]   <= 1'b1;
        end
        if (evict) begin
          rr_ptr <= rr_ptr + SID_W'(1);
          if (evict_count_r != 16'hFFFF) evict_count_r <= evict_count_r + 16'd1;
        end
      end
      if (state == LOAD) first_beat <= 1'b1;
      if (hs) begin
        char_r     <= bus.pkt_data;
        char_vld_r <= 1'b1;
        first_beat <= 1'b0;
        if (bus.pkt_sop && !first_beat) err_sop_r <= 1'b1;
      end
      if (state == EOP) pkt_count_r <= pkt_count_r + 32'd1;
    end
  end

  assign bus.pkt_ready     = ready && rst_n;
  assign bus.stream_id     = sid_r;
  assign bus.new_stream_id = new_r;
  assign bus.load_state    = (state == LOAD);
  assign bus.char_in       = char_r;
  assign bus.char_in_vld   = char_vld_r;
  assign bus.eop           = eop_r;
  assign bus.enable        = enable_r;
  assign bus.busy          = (state != IDLE);
  assign bus.pkt_count     = pkt_count_r;
  assign bus.evict_count   = evict_count_r;
  assign bus.err_sop       = err_sop_r;
endmodule
